// File: rtl/fountain_pkg.sv
// Shared types and LFSR definition for the fountain encoder.
package fountain_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ENCODE} state_t;

  localparam int LFSR_W = 32;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 21;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/fountain_lfsr.sv
// 32-bit Fibonacci LFSR with synchronous seed load and advance enable.
module fountain_lfsr
  import fountain_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr <= DEFAULT_SEED;
    else if (load)   lfsr <= seed;
    else if (adv)    lfsr <= lfsr_next(lfsr);
  end

endmodule

// File: rtl/fountain_v2_encoder.sv
// LT-style fountain encoder: buffers K source symbols, then streams XOR combinations.
// Optional macro FOUNTAIN_SYSTEMATIC_EN makes the first min(K, num_out) outputs systematic.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | accepting K source symbols
//   ENCODE | emitting num_out encoded symbols
module fountain_v2_encoder
  import fountain_pkg::*;
#(
  parameter int SYM_W = 64,
  parameter int K     = 8,
  parameter int ID_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [ID_W-1:0]  num_out,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic [K-1:0]     out_mask,
  output logic [ID_W-1:0]  out_id,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(K);
  localparam logic [K-1:0] ONE_HOT0 = 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  slot;
  logic [ID_W-1:0]   count;
  logic [ID_W-1:0]   num_q;
  logic [SYM_W-1:0]  src_mem [K];
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed_eff;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic              load_acc;
  logic              can_load;
  logic              emit;
  logic              finish;
  logic              sys;
  logic [K-1:0]      mask_nxt;
  logic [SYM_W-1:0]  data_nxt;
  logic              unused_lfsr;

  assign unused_lfsr = ^lfsr;

  always_comb begin
    seed_eff  = (seed == '0) ? DEFAULT_SEED : seed;
    lfsr_load = (state == IDLE) && start;
    load_acc  = (state == LOAD) && in_valid && in_ready;
    can_load  = !out_valid || out_ready;
    emit      = (state == ENCODE) && can_load && (count < num_q);
    finish    = (state == ENCODE) && can_load && (count == num_q);
`ifdef FOUNTAIN_SYSTEMATIC_EN
    sys = (count < ID_W'(K));
`else
    sys = 1'b0;
`endif
    if (sys)                      mask_nxt = ONE_HOT0 << count;
    else if (lfsr[K-1:0] != '0)   mask_nxt = lfsr[K-1:0];
    else                          mask_nxt = ONE_HOT0 << slot;
    lfsr_adv = emit && !sys;
    // Single-level parallel XOR over the selected sources.
    data_nxt = '0;
    for (int i = 0; i < K; i++) begin
      if (mask_nxt[i]) data_nxt = data_nxt ^ src_mem[i];
    end
  end

  fountain_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed_eff),
    .adv   (lfsr_adv),
    .lfsr  (lfsr)
  );

  always_ff @(posedge clk) begin
    if (load_acc) src_mem[idx] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      slot      <= '0;
      count     <= '0;
      num_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_id    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_q    <= num_out;
            idx      <= '0;
            slot     <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (load_acc) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              in_ready <= 1'b0;
              state    <= ENCODE;
            end
          end
        end
        ENCODE: begin
          if (emit) begin
            out_valid <= 1'b1;
            out_data  <= data_nxt;
            out_mask  <= mask_nxt;
            out_id    <= count;
            count     <= count + 1'b1;
            slot      <= (slot == LAST_IDX) ? '0 : slot + 1'b1;
          end else if (finish) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fountain_v2_encoder.sv
// Randomized self-checking bench for fountain_v2_encoder against a queue-based reference model.
module tb_fountain_v2_encoder;

  localparam int SYM_W = 8;
  localparam int K     = 8;
  localparam int ID_W  = 16;
`ifdef FOUNTAIN_SYSTEMATIC_EN
  localparam int SYS_N = K;
`else
  localparam int SYS_N = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      seed = '0;
  logic [ID_W-1:0]  num_out = '0;
  logic             in_valid = 1'b0;
  logic [SYM_W-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [SYM_W-1:0] out_data;
  logic [K-1:0]     out_mask;
  logic [ID_W-1:0]  out_id;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  logic [SYM_W-1:0] src [K];
  logic [K-1:0]     exp_mask [$];
  logic [SYM_W-1:0] exp_data [$];

  always #5 clk = ~clk;

  fountain_v2_encoder #(.SYM_W(SYM_W), .K(K), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_out(num_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_id(out_id), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output list built straight from the coding rules.
  function automatic void build_model(input logic [31:0] sd, input int num);
    logic [31:0]      s;
    logic [K-1:0]     m;
    logic [SYM_W-1:0] d;
    s = (sd == 0) ? 32'h1 : sd;
    exp_mask.delete();
    exp_data.delete();
    for (int n = 0; n < num; n++) begin
      if (n < SYS_N) begin
        m = '0;
        m[n] = 1'b1;
      end else begin
        m = s[K-1:0];
        if (m == '0) begin
          m = '0;
          m[n % K] = 1'b1;
        end
        s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
      end
      d = '0;
      for (int i = 0; i < K; i++) if (m[i]) d = d ^ src[i];
      exp_mask.push_back(m);
      exp_data.push_back(d);
    end
  endfunction

  // mode: 0 always ready, 1 random ready, 2 stall id 1 for 4 cycles
  task automatic run_block(input logic [31:0] sd, input int num, input int mode,
                           input bit poke, input bit abort);
    int j, k, it, stall;
    bit got_done, first_seen;
    build_model(sd, num);
    @(negedge clk);
    start = 1'b1; seed = sd; num_out = ID_W'(num);
    @(negedge clk);
    start = 1'b0; seed = $urandom;
    j = 0; it = 0;
    while (j < K && it < 200) begin
      if (poke && j == 3) begin
        start = 1'b1; seed = sd ^ 32'h5a5a_1234; num_out = ID_W'(num + 5);
      end else begin
        start = 1'b0; num_out = ID_W'(num);
      end
      if (in_ready && $urandom_range(3) != 0) begin
        in_valid = 1'b1; in_data = src[j]; j++;
      end else begin
        in_valid = 1'b0; in_data = $urandom;
      end
      it++;
      @(negedge clk);
    end
    start = 1'b0; num_out = ID_W'(num);
    if (j < K) check("load_timeout", 64'(j), 64'(K));
    check("in_ready_after_load", 64'(in_ready), 64'd0);
    check("busy_after_load", 64'(busy), 64'd1);
    k = 0; it = 1; stall = 0; got_done = 0; first_seen = 0;
    while (it < 400) begin
      if (abort && k == 2) begin
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_mask", 64'(out_mask), 64'd0);
        check("abort_out_id", 64'(out_id), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      in_valid = 1'($urandom); in_data = $urandom;
      if (done) begin
        got_done = 1;
        check("done_count", 64'(k), 64'(num));
        if (num == 0) check("done_latency", 64'(it), 64'd2);
        break;
      end
      if (out_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          check("first_valid_latency", 64'(it), 64'd2);
        end
        if (k >= num) begin
          check("extra_output", 64'(out_valid), 64'd0);
          break;
        end
        check("out_id", 64'(out_id), 64'(k));
        check("out_mask", 64'(out_mask), 64'(exp_mask[k]));
        check("out_data", 64'(out_data), 64'(exp_data[k]));
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(2) != 0);
        default: begin
          if (out_valid && k == 1 && stall < 4) begin
            out_ready = 1'b0; stall++;
          end else out_ready = 1'b1;
        end
      endcase
      if (out_valid && out_ready) k++;
      it++;
      @(negedge clk);
    end
    if (!got_done) check("done_seen", 64'd0, 64'd1);
    if (mode == 2 && num > 1) check("stall_cycles", 64'(stall), 64'd4);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    check("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < K; i++) src[i] = SYM_W'(i + 1);
    run_block(32'd1, 3, 0, 1'b0, 1'b0);
    run_block(32'd1, 3, 2, 1'b0, 1'b0);
    run_block(32'd0, 3, 0, 1'b0, 1'b0);
    run_block(32'd1, 0, 0, 1'b0, 1'b0);
    run_block(32'd1, 10, 0, 1'b0, 1'b0);
    run_block(32'd1, 5, 0, 1'b0, 1'b1);
    run_block(32'd1, 3, 0, 1'b0, 1'b0);
    run_block(32'hace1, 6, 0, 1'b1, 1'b0);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < K; i++) src[i] = SYM_W'($urandom);
      run_block($urandom, int'($urandom_range(20)), 1, 1'($urandom), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
